// File: rtl/and2_bank_arbiter.sv
// Round-robin sequencer that time-shares one registered WIDTH-bit and2 bank
// between NUM_REQ requesters: grant, capture operands, evaluate, respond.
module and2_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [15:0]              txn_count
);

  typedef enum logic [1:0] {IDLE, GRANT, EVAL, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   win_id_reg, win_id_next;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic              capture, load_rsp, handshake;
  logic [WIDTH-1:0]  op_a_reg, op_b_reg;
  logic [WIDTH-1:0]  bank_out;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [15:0]       txn_count_reg;
  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
    assign gnt[gi]   = (state_reg == GRANT) && (win_id_reg == ID_W'(gi));
  end

  // The shared bank: one and2 per bit, fed only by the captured operands.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_and2
    assign bank_out[gi] = op_a_reg[gi] & op_b_reg[gi];
  end

  // Scan downward so the last hit is the one nearest to ptr; the wrap keeps
  // the index inside 0..NUM_REQ-1 for any NUM_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    win_id_next = win_id_reg;
    ptr_next    = ptr_reg;
    capture     = 1'b0;
    load_rsp    = 1'b0;
    handshake   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          win_id_next = pick_id;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request abandons the slot without moving the pointer.
        if (req[win_id_reg]) begin
          capture    = 1'b1;
          state_next = EVAL;
        end else begin
          state_next = IDLE;
        end
      end
      EVAL: begin
        load_rsp   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
          ptr_next   = (win_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : win_id_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      win_id_reg    <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      txn_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      win_id_reg <= win_id_next;
      if (capture) begin
        op_a_reg <= a_arr[win_id_reg];
        op_b_reg <= b_arr[win_id_reg];
      end
      if (load_rsp) begin
        rsp_data_reg <= bank_out;
        rsp_id_reg   <= win_id_reg;
      end
      if (handshake) txn_count_reg <= txn_count_reg + 16'd1;
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_and2_bank_arbiter.sv
// Directed bench for and2_bank_arbiter: a 4-requester instance driven from a
// vector table plus hand sequences, and a 3-requester instance for wrap cases.
module tb_and2_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [15:0] txn_count;

  logic [2:0]  req3;
  logic [23:0] a3, b3;
  logic [2:0]  gnt3;
  logic        rsp_valid3, rsp_ready3, busy3;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_data3;
  logic [15:0] txn_count3;

  and2_bank_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .txn_count(txn_count)
  );

  and2_bank_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .a_in(a3), .b_in(b3),
    .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_data(rsp_data3), .busy(busy3), .txn_count(txn_count3)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    logic [7:0]  data;
    int          stall;
  } vec_t;

  vec_t        vecs [11];
  vec_t        v;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_txn = 16'd0;
  logic [15:0] exp_txn3 = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic txn4(input vec_t tv, input string nm);
    logic [3:0] exp_gnt;
    exp_gnt   = 4'b0001 << tv.id;
    req       = tv.req;
    a_in      = tv.a;
    b_in      = tv.b;
    rsp_ready = (tv.stall == 0);
    @(negedge clk);
    chk({nm, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    @(negedge clk);
    chk({nm, ".early_valid"}, 32'({busy, rsp_valid}), 32'(2'b10));
    @(negedge clk);
    chk({nm, ".resp"}, 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 2'(tv.id), tv.data}));
    for (int i = 1; i < tv.stall; i++) begin
      @(negedge clk);
      chk({nm, ".hold"}, 32'({rsp_valid, rsp_id, rsp_data, gnt}),
          32'({1'b1, 2'(tv.id), tv.data, 4'b0000}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_txn = exp_txn + 16'd1;
    chk({nm, ".done"}, 32'({busy, rsp_valid}), 32'd0);
    chk({nm, ".count"}, 32'(txn_count), 32'(exp_txn));
    $display("txn %s: req=%b id=%0d data=%h count=%0d", nm, tv.req, rsp_id, rsp_data, txn_count);
  endtask

  task automatic txn3(input logic [2:0] r, input logic [23:0] a, input logic [23:0] b,
                      input int id, input logic [7:0] d, input string nm);
    req3 = r; a3 = a; b3 = b; rsp_ready3 = 1'b1;
    @(negedge clk);
    chk({nm, ".gnt"}, 32'(gnt3), 32'(3'b001 << id));
    @(negedge clk);
    @(negedge clk);
    chk({nm, ".resp"}, 32'({rsp_valid3, rsp_id3, rsp_data3}), 32'({1'b1, 2'(id), d}));
    @(negedge clk);
    exp_txn3 = exp_txn3 + 16'd1;
    chk({nm, ".count"}, 32'({busy3, rsp_valid3, txn_count3}), 32'({2'b00, exp_txn3}));
    $display("txn %s: req=%b id=%0d data=%h count=%0d", nm, r, rsp_id3, rsp_data3, txn_count3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Requester operands packed {r3, r2, r1, r0}; ptr progression noted per entry.
    vecs[0]  = '{4'b1111, 32'h0FF0AAFF, 32'hFF3C5581, 0, 8'h81, 0};  // ptr 0 -> 1
    vecs[1]  = '{4'b1111, 32'h0FF0AAFF, 32'hFF3C5581, 1, 8'h00, 0};  // -> 2
    vecs[2]  = '{4'b1111, 32'h0FF0AAFF, 32'hFF3C5581, 2, 8'h30, 0};  // -> 3
    vecs[3]  = '{4'b1111, 32'h0FF0AAFF, 32'hFF3C5581, 3, 8'h0F, 0};  // -> 0
    vecs[4]  = '{4'b1111, 32'h0FF0AAFF, 32'hFF3C5581, 0, 8'h81, 0};  // -> 1
    vecs[5]  = '{4'b0100, 32'h00F00000, 32'h003C0000, 2, 8'h30, 0};  // -> 3
    vecs[6]  = '{4'b0011, 32'h12345678, 32'hFFFFF00F, 0, 8'h08, 0};  // wraps 3->0, -> 1
    vecs[7]  = '{4'b1001, 32'h12345678, 32'hFFFFF00F, 3, 8'h12, 0};  // -> 0
    vecs[8]  = '{4'b1010, 32'hC300E700, 32'h81007E00, 1, 8'h66, 0};  // -> 2
    vecs[9]  = '{4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8'hFF, 0};  // -> 1
    vecs[10] = '{4'b1000, 32'h00000000, 32'hFFFFFFFF, 3, 8'h00, 0};  // -> 0

    req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
    req3 = '0; a3 = '0; b3 = '0; rsp_ready3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset4", 32'({busy, rsp_valid, gnt, rsp_id, rsp_data, txn_count}), 32'd0);
    chk("reset3", 32'({busy3, rsp_valid3, gnt3, rsp_id3, rsp_data3, txn_count3}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn4(vecs[i], $sformatf("v%0d", i));
      if (i == 4) chk("fair.count5", 32'(txn_count), 32'd5);
    end
    req = '0;

    // Reset landing in RESP, with ptr advanced to 3 beforehand.
    v = '{4'b0100, 32'h00AA0000, 32'h000F0000, 2, 8'h0A, 0};
    txn4(v, "rst.pre");
    req = 4'b1000; a_in = 32'hFF000000; b_in = 32'hFF000000; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.in_resp", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async", 32'({busy, rsp_valid, gnt, txn_count}), 32'd0);
    exp_txn = 16'd0;
    exp_txn3 = 16'd0;
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'b1010, 32'h00005A00, 32'h0000FF00, 1, 8'h5A, 0};
    txn4(v, "rst.first");
    req = '0;

    // Backpressure: ten RESP cycles with rsp_ready low.
    v = '{4'b0100, 32'h00C30000, 32'h005A0000, 2, 8'h42, 10};
    txn4(v, "bp");
    req = '0;

    // Withdraw during GRANT: ptr stays at 3.
    req = 4'b1000; a_in = 32'hFF000000; b_in = 32'hFF000000; rsp_ready = 1'b1;
    @(negedge clk);
    chk("wd.gnt", 32'(gnt), 32'(4'b1000));
    req = '0;
    @(negedge clk);
    chk("wd.idle", 32'({busy, rsp_valid}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("wd.novalid", 32'({busy, rsp_valid}), 32'd0);
    end
    chk("wd.count", 32'(txn_count), 32'(exp_txn));
    $display("txn wd: req=1000 withdrawn, count=%0d", txn_count);
    v = '{4'b1001, 32'h77000011, 32'h0F0000FF, 3, 8'h07, 0};
    txn4(v, "wd.ptr");
    req = '0;

    // NUM_REQ=3: pointer wrap from 2 and counter wrap from 0xFFFF.
    txn3(3'b011, 24'h003C96, 24'h00F00F, 0, 8'h06, "w3.a");
    txn3(3'b011, 24'h003C96, 24'h00F00F, 1, 8'h30, "w3.b");
    req3 = '0;
    dut3.txn_count_reg = 16'hFFFF;
    exp_txn3 = 16'hFFFF;
    txn3(3'b011, 24'h00FFA5, 24'h00FF3C, 0, 8'h24, "w3.wrap");
    req3 = '0;
    chk("w3.count0", 32'(txn_count3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
